qsystuto_keys_in: RTL and testbench

QSYSTUTO_KEYS_IN -- requirements
Module: qsystuto_keys_in

---
 rtl/qsystuto_keys_in_if.sv | 19 +
 rtl/qsystuto_keys_in.sv | 100 ++++++++++
 tb/tb_qsystuto_keys_in.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/qsystuto_keys_in_if.sv
// Avalon-MM slave bus of the push-key input block: word address, select,
// active-low write strobe, write data and zero-latency read data.
interface qsystuto_keys_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qsystuto_keys_in.sv
// Debounced push-key input port: 2-flop synchronizer, per-bit debounce counter,
// edge capture with write-1-to-clear, interrupt mask and level irq.
module qsystuto_keys_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  qsystuto_keys_in_if.slave     avs,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int CW = 16;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RESERVED = 2'd1,
    ADDR_MASK     = 2'd2,
    ADDR_EDGE     = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [CW-1:0]    cnt [WIDTH];

  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  assign wr           = avs.chipselect && !avs.write_n;
  assign clr          = (wr && avs.address == ADDR_EDGE) ? avs.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^avs.writedata;

  // A bit accepts its new level on the edge where its counter would hit the limit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (sync[i] != db[i]) && (({1'b0, cnt[i]} + 17'd1) == LIMIT);
    end
  end

  assign edge_ev = (EDGE_TYPE == 0) ? (upd & sync)  :
                   (EDGE_TYPE == 1) ? (upd & ~sync) :
                                      upd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta   <= '1;
      sync        <= '1;
      db          <= '1;
      irqmask     <= '0;
      edgecapture <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
      // to discard any debounce in progress.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_meta <= in_port;
      sync      <= sync_meta;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == db[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
      db <= (db & ~upd) | (sync & upd);
      if (wr && avs.address == ADDR_MASK) begin
        irqmask <= avs.writedata[WIDTH-1:0];
      end
      // Set wins over a simultaneous clear of the same bit.
      edgecapture <= (edgecapture & ~clr) | edge_ev;
    end
  end

  always_comb begin
    avs.readdata = '0;
    case (reg_addr_e'(avs.address))
      ADDR_DATA: avs.readdata = 32'(db);
      ADDR_MASK: avs.readdata = 32'(irqmask);
      ADDR_EDGE: avs.readdata = 32'(edgecapture);
      default:   avs.readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_qsystuto_keys_in.sv
// Bench for qsystuto_keys_in: falling-edge (A) and any-edge (B) instances share
// inputs; a sample-history model predicts both, plus directed literal checks.
module tb_qsystuto_keys_in;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic [1:0]   address;
  logic         cs;
  logic         wn;
  logic [31:0]  wd;
  logic         irq_a, irq_b;
  logic         chk_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  qsystuto_keys_in_if bus_a ();
  qsystuto_keys_in_if bus_b ();

  assign bus_a.address = address;  assign bus_b.address = address;
  assign bus_a.chipselect = cs;    assign bus_b.chipselect = cs;
  assign bus_a.write_n = wn;       assign bus_b.write_n = wn;
  assign bus_a.writedata = wd;     assign bus_b.writedata = wd;

  qsystuto_keys_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .avs(bus_a), .in_port(in_port), .irq(irq_a)
  );

  qsystuto_keys_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .avs(bus_b), .in_port(in_port), .irq(irq_b)
  );

  // ---------------- behavioural model ----------------
  // A bit adopts a new level once the last D synchronized samples all showed it.
  logic [W-1:0] m_meta, m_sync, m_db;
  logic [W-1:0] m_mask [2];
  logic [W-1:0] m_ec   [2];
  logic [W-1:0] hist [$];
  logic [W-1:0] s, upd, clr, ev;
  bit           all_same;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_meta = '1; m_sync = '1; m_db = '1;
      hist.delete();
      for (int k = 0; k < 2; k++) begin
        m_mask[k] = '0; m_ec[k] = '0;
      end
    end else begin
      s = m_sync;
      hist.push_back(s);
      if (hist.size() > D) void'(hist.pop_front());
      upd = '0;
      for (int i = 0; i < W; i++) begin
        if (m_db[i] != s[i] && hist.size() == D) begin
          all_same = 1'b1;
          foreach (hist[j]) if (hist[j][i] != s[i]) all_same = 1'b0;
          upd[i] = all_same;
        end
      end
      clr = (cs && !wn && address == 2'd3) ? wd[W-1:0] : '0;
      for (int k = 0; k < 2; k++) begin
        ev = (k == 0) ? (upd & ~s) : upd;
        m_ec[k] = (m_ec[k] & ~clr) | ev;
        if (cs && !wn && address == 2'd2) m_mask[k] = wd[W-1:0];
      end
      m_db   = m_db ^ upd;
      m_sync = m_meta;
      m_meta = in_port;
    end
  end

  function automatic logic [31:0] model_rd(int k, logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_db);
      2'd2:    return 32'(m_mask[k]);
      2'd3:    return 32'(m_ec[k]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd_a", bus_a.readdata, model_rd(0, address));
      check("model_rd_b", bus_b.readdata, model_rd(1, address));
      check("model_irq_a", 32'(irq_a), 32'(|(m_ec[0] & m_mask[0])));
      check("model_irq_b", 32'(irq_b), 32'(|(m_ec[1] & m_mask[1])));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] exp, string name);
    address = a;
    #1;
    check(name, bus_a.readdata, exp);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a; wd = d; cs = 1'b1; wn = 1'b0;
    tick(1);
    cs = 1'b0; wn = 1'b1;
  endtask

  int hold [W];

  initial begin
    reset_n = 1'b0; in_port = '1; address = '0; cs = 1'b0; wn = 1'b1; wd = '0;
    tick(3);
    chk_en = 1'b1;
    reset_n = 1'b1;
    tick(1);

    // Reset state
    rd(0, 32'hF, "rst_data");
    rd(2, 32'h0, "rst_mask");
    rd(3, 32'h0, "rst_cap");
    check("rst_irq", 32'(irq_a), 32'h0);

    // Bit 0 falls: db changes on exactly the sixth edge
    in_port = 4'hE;
    tick(5);
    rd(0, 32'hF, "fall_early");
    tick(1);
    rd(0, 32'hE, "fall_db");
    check("model_fall_db", 32'(m_db), 32'hE);
    rd(3, 32'h1, "fall_cap");
    check("fall_cap_b", bus_b.readdata, 32'h1);
    check("fall_irq_masked", 32'(irq_a), 32'h0);
    wr(2, 32'hFFFF_FFF1);
    check("mask_irq", 32'(irq_a), 32'h1);
    rd(2, 32'h1, "mask_rd");

    // Three-cycle glitch on bit 1 is rejected
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(10);
    rd(0, 32'hE, "glitch_db");
    rd(3, 32'h1, "glitch_cap");
    rd(1, 32'h0, "reserved_rd");

    // Write-1-to-clear
    wr(3, 32'h1);
    rd(3, 32'h0, "w1c_cap");
    check("w1c_irq", 32'(irq_a), 32'h0);

    // Release bit 0: no falling capture, any-edge instance captures the rise
    in_port = 4'hF;
    tick(6);
    rd(0, 32'hF, "rise_db");
    rd(3, 32'h0, "rise_nocap_a");
    check("rise_cap_b", bus_b.readdata, 32'h1);
    check("model_rise_cap_b", 32'(m_ec[1]), 32'h1);
    wr(3, 32'hF);

    // Clear landing on the db-update edge: set wins
    in_port = 4'hE;
    tick(5);
    wr(3, 32'h1);
    rd(3, 32'h1, "set_wins");
    check("set_wins_irq", 32'(irq_a), 32'h1);
    wr(3, 32'hF);
    in_port = 4'hF;
    tick(8);
    wr(3, 32'hF);
    rd(3, 32'h0, "cleared_again");

    // Reset two cycles into a bit-2 debounce
    in_port = 4'hB;
    tick(4);
    reset_n = 1'b0;
    rd(0, 32'hF, "rst_mid_db");
    rd(2, 32'h0, "rst_mid_mask");
    check("rst_mid_irq", 32'(irq_a), 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    rd(0, 32'hF, "rel_early");
    tick(1);
    rd(0, 32'hB, "rel_db");
    rd(3, 32'h4, "rel_cap");

    // Randomized phase, checked by the model every cycle
    for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 9);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          in_port[b] = ~in_port[b];
          hold[b] = $urandom_range(1, 9);
        end else begin
          hold[b]--;
        end
      end
      address = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       begin cs = 1'b1; wn = 1'b0; wd = $urandom; end
        1:       begin cs = 1'b1; wn = 1'b1; wd = $urandom; end
        default: begin cs = 1'b0; wn = 1'($urandom_range(0, 1)); wd = $urandom; end
      endcase
      reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end

    cs = 1'b0; wn = 1'b1; reset_n = 1'b1;
    tick(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
